vec_dot_sequencer: RTL and testbench

Sequencer that drives the shared adder tree to compute dot products longer than one tree width. It accepts a job of `num_chunks` chunks, each `MATRIX_SIZE` signed products, at one chunk per cycle and presents each chunk to the adder tree. It sign-extends and accumulates each tree sum into a wide accumulator and returns the total on a valid/ready result port. It sits between the multiplier array, which supplies the products, and the downstream result consumer.

---
 rtl/vec_dot_sequencer.sv | 117 +++++++++++
 tb/tb_vec_dot_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_dot_sequencer.sv
// Chunked dot-product sequencer: feeds the shared adder tree one chunk per
// cycle and accumulates the sign-extended tree sums into a wide total.
module vec_dot_sequencer #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int PARTIAL_MUL_BW = 16,
    parameter int MATRIX_SIZE    = 8,
    parameter int ACC_BW         = 32,
    parameter int CNT_BW         = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [CNT_BW-1:0]                     num_chunks,
    input  logic                                  abort,
    output logic                                  busy,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PARTIAL_MUL_BW*MATRIX_SIZE-1:0] in_data_flat,
    output logic [PARTIAL_MUL_BW*MATRIX_SIZE-1:0] tree_data_flat,
    input  logic [PARTIAL_SUM_BW-1:0]             tree_sum,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_BW-1:0]                     out_sum,
    output logic                                  out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_BW-1:0] num_r;
    logic [CNT_BW-1:0] cnt;
    logic              s1_valid;
    logic [ACC_BW-1:0] acc;
    logic [ACC_BW-1:0] ext;
    logic [ACC_BW-1:0] acc_add;
    logic              acc_ovf;
    logic              add_ovf;
    logic              in_fire;
    logic              start_ok;
    logic              last_acc;

    assign start_ok = (state == IDLE) && start && (num_chunks != '0);
    assign busy     = (state != IDLE);
    assign in_ready = (state == RUN) && (cnt < num_r);
    assign in_fire  = in_valid && in_ready;
    assign last_acc = s1_valid && (cnt == num_r) && !in_fire;

    assign out_valid = (state == DONE);
    assign out_sum   = out_valid ? acc : '0;
    assign out_ovf   = out_valid && acc_ovf;

    // Overflow: operands agree in sign but the result does not
    assign ext     = ACC_BW'($signed(tree_sum));
    assign acc_add = acc + ext;
    assign add_ovf = (acc[ACC_BW-1] == ext[ACC_BW-1]) &&
                     (acc_add[ACC_BW-1] != acc[ACC_BW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = RUN;
            end
            RUN: begin
                if (abort)         state_nx = IDLE;
                else if (last_acc) state_nx = DONE;
            end
            DONE: begin
                if (abort || out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_r          <= '0;
            cnt            <= '0;
            s1_valid       <= 1'b0;
            acc            <= '0;
            acc_ovf        <= 1'b0;
            tree_data_flat <= '0;
        end else if (start_ok) begin
            num_r    <= num_chunks;
            cnt      <= '0;
            s1_valid <= 1'b0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
        end else if (state == RUN && !abort) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                tree_data_flat <= in_data_flat;
                cnt            <= cnt + CNT_BW'(1);
            end
            if (s1_valid) begin
                acc     <= acc_add;
                acc_ovf <= acc_ovf | add_ovf;
            end
        end else begin
            s1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_dot_sequencer.sv
// Directed bench for vec_dot_sequencer with a behavioural adder tree.
// A second instance with a 20-bit accumulator exercises overflow.
module tb_vec_dot_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start2;
    logic [7:0]   num_chunks;
    logic         abort;
    logic         in_valid;
    logic [127:0] in_data_flat;
    logic         out_ready;

    logic         busy, in_ready, out_valid, out_ovf;
    logic [127:0] tree_data_flat;
    logic [19:0]  tree_sum;
    logic [31:0]  out_sum;

    logic         busy2, in_ready2, out_valid2, out_ovf2;
    logic [127:0] tree_data_flat2;
    logic [19:0]  out_sum2;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt = 0;
    int hs_cnt  = 0;
    bit ov_seen = 0;

    logic signed [15:0] vals [4];

    always #5 clk = ~clk;

    vec_dot_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
        .abort(abort), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_flat(in_data_flat), .tree_data_flat(tree_data_flat),
        .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    vec_dot_sequencer #(.ACC_BW(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_chunks(num_chunks),
        .abort(abort), .busy(busy2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data_flat(in_data_flat), .tree_data_flat(tree_data_flat2),
        .tree_sum(20'h40000), .out_valid(out_valid2), .out_ready(out_ready),
        .out_sum(out_sum2), .out_ovf(out_ovf2)
    );

    logic signed [19:0] tsum;
    always_comb begin
        tsum = '0;
        for (int i = 0; i < 8; i++)
            tsum = tsum + 20'($signed(tree_data_flat[i*16 +: 16]));
    end
    assign tree_sum = tsum;

    always @(posedge clk) begin
        if (in_ready) rdy_cnt = rdy_cnt + 1;
        if (out_valid && out_ready) hs_cnt = hs_cnt + 1;
        if (out_valid) ov_seen = 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_chunks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int b;
            in_data_flat = {8{vals[i]}};
            in_valid = 1'b1;
            b = 0;
            while (!in_ready && b < 20) begin
                @(negedge clk);
                b++;
            end
            chk("rdy", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic job(input string tag, input int n, input int gap,
                       input int stall, input logic [31:0] es);
        int k;
        @(negedge clk);
        start = 1'b1;
        num_chunks = 8'(n);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        send_chunks(n, 0 + gap);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (gap == 0) chk({tag, ".lat"}, 32'(k), 32'd1);
        chk({tag, ".sum"}, out_sum, es);
        chk({tag, ".ovf"}, 32'(out_ovf), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, ".hold"}, out_sum, es);
            chk({tag, ".hvld"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".rel"}, 32'(busy | out_valid), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        num_chunks = '0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data_flat = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        chk("rst.vld", 32'(out_valid), 32'd0);
        chk("rst.sum", out_sum, 32'd0);
        chk("rst.tree", 32'(tree_data_flat == '0), 32'd1);
        rst_n = 1'b1;

        vals = '{16'sd3, 16'sd0, 16'sd0, 16'sd0};
        job("one", 1, 0, 0, 32'd24);

        vals = '{16'sd1, -16'sd2, 16'sd100, -16'sd32768};
        rdy_cnt = 0;
        job("four", 4, 0, 0, 32'(-261352));
        chk("four.rdycyc", 32'(rdy_cnt), 32'd4);

        vals = '{16'sd5, -16'sd7, 16'sd1000, 16'sd0};
        hs_cnt = 0;
        job("gap", 3, 2, 5, 32'd7984);
        @(negedge clk);
        chk("gap.hs", 32'(hs_cnt), 32'd1);

        @(negedge clk);
        start2 = 1'b1;
        num_chunks = 8'd16;
        @(negedge clk);
        start2 = 1'b0;
        in_valid = 1'b1;
        in_data_flat = '0;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ovf.vld", 32'(out_valid2), 32'd1);
        chk("ovf.flag", 32'(out_ovf2), 32'd1);
        chk("ovf.sum", 32'(out_sum2), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ovf.rel", 32'(busy2), 32'd0);

        vals = '{16'sd9, 16'sd9, 16'sd9, 16'sd9};
        @(negedge clk);
        start = 1'b1;
        num_chunks = 8'd5;
        @(negedge clk);
        start = 1'b0;
        ov_seen = 0;
        send_chunks(2, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt.busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("abt.novld", 32'(ov_seen), 32'd0);
        vals = '{-16'sd4, 16'sd0, 16'sd0, 16'sd0};
        job("post", 1, 0, 0, 32'(-32));

        @(negedge clk);
        start = 1'b1;
        num_chunks = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero.busy", 32'(busy), 32'd0);

        vals = '{16'sd7, 16'sd7, 16'sd7, 16'sd7};
        start = 1'b1;
        num_chunks = 8'd3;
        @(negedge clk);
        start = 1'b0;
        send_chunks(1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.rdy", 32'(in_ready), 32'd0);
        chk("arst.vld", 32'(out_valid), 32'd0);
        chk("arst.sum", out_sum, 32'd0);
        chk("arst.tree", 32'(tree_data_flat == '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        vals = '{16'sd10, 16'sd20, 16'sd0, 16'sd0};
        job("afterrst", 2, 0, 0, 32'd240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
